// File: rtl/execute_divide_pkg.sv
// Shared constants, state encoding and helpers for the
// iterative execute-stage divider.
package execute_divide_pkg;

   localparam int REGSZ = 32;
   localparam int CNTW  = 6;

   localparam logic [REGSZ-1:0] REG_ZERO = '0;
   localparam logic [REGSZ-1:0] REG_ONES = '1;
   localparam logic [REGSZ-1:0] REG_MINV = {1'b1, {(REGSZ-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   // Magnitude of an operand; the most negative value maps onto
   // itself, which is the correct unsigned magnitude.
   function automatic logic [REGSZ-1:0] mag(
      input logic [REGSZ-1:0] x,
      input logic             sgn
   );
      return (sgn && x[REGSZ-1]) ? (REG_ZERO - x) : x;
   endfunction

endpackage

// File: rtl/execute_divide_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, restore on borrow.
module divide_step
   import execute_divide_pkg::*;
(
   input  logic [REGSZ-1:0] rem_i,
   input  logic             msb_i,
   input  logic [REGSZ-1:0] dvs_i,
   output logic [REGSZ-1:0] rem_o,
   output logic             qbit_o
);

   logic [REGSZ:0] shifted;
   logic [REGSZ:0] diff;
   logic           unused_diff_top;

   // Remainder stays below the divisor, so REGSZ+1 bits hold the
   // shifted value and either result fits back in REGSZ bits.
   always_comb begin
      shifted = {rem_i, msb_i};
      diff    = shifted - {1'b0, dvs_i};
      qbit_o  = (shifted >= {1'b0, dvs_i});
      rem_o   = qbit_o ? diff[REGSZ-1:0] : shifted[REGSZ-1:0];
   end

   assign unused_diff_top = diff[REGSZ];

endmodule

// File: rtl/execute_divide.sv
// Iterative restoring divider for divw/divwu, one quotient
// bit per cycle, valid/ready on both sides with flush.
module execute_divide
   import execute_divide_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [REGSZ-1:0] in_a,
   input  logic [REGSZ-1:0] in_b,
   input  logic             in_signed,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [REGSZ-1:0] out_result,
   output logic             out_ov
);

   div_state_e       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [REGSZ-1:0] rem_q, rem_d;
   logic [REGSZ-1:0] dvd_q, dvd_d;
   logic [REGSZ-1:0] dvs_q, dvs_d;
   logic [REGSZ-1:0] res_q, res_d;
   logic             qneg_q, qneg_d;
   logic             ov_q, ov_d;

   logic [REGSZ-1:0] step_rem;
   logic             step_qbit;
   logic             special;

   divide_step u_step (
      .rem_i  (rem_q),
      .msb_i  (dvd_q[REGSZ-1]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   assign special = (in_b == REG_ZERO) ||
                    (in_signed && in_a == REG_MINV &&
                     in_b == REG_ONES);

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_ov     = ov_q;

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         qneg_q  <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         qneg_q  <= qneg_d;
         ov_q    <= ov_d;
      end
   end

   // Next state: accept, iterate, sign-fix, hold until taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      qneg_d  = qneg_q;
      ov_d    = ov_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               dvd_d  = mag(in_a, in_signed);
               dvs_d  = mag(in_b, in_signed);
               qneg_d = in_signed &
                        (in_a[REGSZ-1] ^ in_b[REGSZ-1]);
               rem_d  = '0;
               cnt_d  = CNTW'(REGSZ-1);
               if (special) begin
                  res_d   = '0;
                  ov_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[REGSZ-2:0], step_qbit};
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            res_d   = qneg_q ? (REG_ZERO - dvd_q) : dvd_q;
            ov_d    = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
      end
   end

endmodule
